// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the debounce_pulse block
//   state_t       : debounce FSM states
//   EDGE_*        : EDGE_MODE encodings for pulse_out selection
//   select_pulse  : maps accepted rise/fall events onto pulse_out
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic logic select_pulse(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for a single asynchronous bit
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output, STAGES clocks after d is first sampled
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - debounces a noisy asynchronous input into a level and one-cycle edge pulses
//   clk        : system clock
//   rst        : synchronous active-high reset
//   din        : raw asynchronous input
//   level      : debounced level (registered)
//   rise_pulse : one-cycle pulse on an accepted 0->1
//   fall_pulse : one-cycle pulse on an accepted 1->0
//   pulse_out  : rise, fall or both per EDGE_MODE; intended as a counter enable
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic pulse_out
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  // Entering a WAIT state already counts one sample, so acceptance happens
  // when the counter shows DEBOUNCE_CYCLES-1 and one more matching sample arrives.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_pulse: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_pulse: DEBOUNCE_CYCLES must be >= 2");
  end
  if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
    $error("debounce_pulse: EDGE_MODE must be 0, 1 or 2");
  end

  logic s;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s)
  );

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 level_next;
  logic                 rise_next;
  logic                 fall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      pulse_out  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      level      <= level_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      pulse_out  <= select_pulse(EDGE_MODE, rise_next, fall_next);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// tb/tb_debounce_pulse.sv - self-checking bench for debounce_pulse in all three edge modes
module tb_debounce_pulse;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic l0, r0, f0, p0;
  logic l1, r1, f1, p1;
  logic l2, r2, f2, p2;

  debounce_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut_rise (
    .clk(clk), .rst(rst), .din(din),
    .level(l0), .rise_pulse(r0), .fall_pulse(f0), .pulse_out(p0));

  debounce_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1)) dut_fall (
    .clk(clk), .rst(rst), .din(din),
    .level(l1), .rise_pulse(r1), .fall_pulse(f1), .pulse_out(p1));

  debounce_pulse #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)) dut_both (
    .clk(clk), .rst(rst), .din(din),
    .level(l2), .rise_pulse(r2), .fall_pulse(f2), .pulse_out(p2));

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic po_rise;
    logic po_fall;
    logic po_both;
  } out_t;

  typedef struct packed {
    logic din;
    logic rst;
    out_t exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  out_t exp_q[$];

  // Reference model state: two-flop synchronizer and a run-length acceptor.
  logic [1:0] m_sync = 2'b00;
  logic       m_lvl  = 1'b0;
  int         m_run  = 0;

  // Event counters observed on the DUT outputs (counters attached to pulse_out).
  int   pc0 = 0, pc1 = 0, pc2 = 0, rc0 = 0, fc0 = 0;
  int   consec = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  always @(negedge clk) begin
    if (p0) pc0++;
    if (p1) pc1++;
    if (p2) pc2++;
    if (r0) rc0++;
    if (f0) fc0++;
    if (p1 && prev1) consec++;
    if (p2 && prev2) consec++;
    prev1 = p1;
    prev2 = p2;
  end

  task automatic model_next(input logic d, input logic r, output out_t o);
    logic s;
    o = '0;
    if (r) begin
      m_sync = 2'b00;
      m_lvl  = 1'b0;
      m_run  = 0;
    end else begin
      s      = m_sync[1];
      m_sync = {m_sync[0], d};
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DC) begin
          m_lvl  = s;
          m_run  = 0;
          o.rise = s;
          o.fall = !s;
        end
      end else begin
        m_run = 0;
      end
    end
    o.level   = m_lvl;
    o.po_rise = o.rise;
    o.po_fall = o.fall;
    o.po_both = o.rise | o.fall;
  endtask

  task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic d, input logic r, input out_t e);
    out_t x;
    @(negedge clk);
    din = d;
    rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc);
    end else begin
      x = exp_q.pop_front();
      check_vec("outputs", {l0, r0, f0, p0, p1, p2}, x);
      check_vec("alt_outputs", {l1, r1, f1, l2, r2, f2},
                {x.level, x.rise, x.fall, x.level, x.rise, x.fall});
    end
    cyc++;
  endtask

  task automatic step(input logic d, input logic r);
    out_t e;
    model_next(d, r, e);
    apply(d, r, e);
  endtask

  function automatic vec_t mk(input logic d, input logic r, input logic l, input logic ri,
                              input logic fa, input logic pr, input logic pf, input logic pb);
    vec_t v;
    v.din         = d;
    v.rst         = r;
    v.exp.level   = l;
    v.exp.rise    = ri;
    v.exp.fall    = fa;
    v.exp.po_rise = pr;
    v.exp.po_fall = pf;
    v.exp.po_both = pb;
    return v;
  endfunction

  vec_t tab[18];
  out_t dummy;
  int   b0, b1, b2, brc, bfc, first, exp_falls, exp_rises, nruns, len;
  logic v, prev, target;

  initial begin
    // Reset, then a clean press (din high from table row 2) and release (row 10).
    tab[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tab[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tab[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tab[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tab[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tab[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tab[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tab[7]  = mk(1, 0, 1, 1, 0, 1, 0, 1);
    tab[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
    tab[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
    tab[10] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tab[11] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tab[12] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tab[13] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tab[14] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 0, 1, 0, 1, 1);
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      model_next(tab[i].din, tab[i].rst, dummy);
      apply(tab[i].din, tab[i].rst, tab[i].exp);
    end

    // Repeated 3-cycle glitches never reach acceptance.
    b0 = pc0; b1 = pc1; b2 = pc2;
    for (int rep = 0; rep < 10; rep++) begin
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    end
    for (int j = 0; j < 6; j++) step(1'b0, 1'b0);
    check_int("glitch_pulses", (pc0 - b0) + (pc1 - b1) + (pc2 - b2), 0);
    check_int("glitch_level", int'(l0), 0);

    // Clean press and release, each held 20 cycles.
    b0 = pc0; b1 = pc1; b2 = pc2;
    for (int j = 0; j < 20; j++) step(1'b1, 1'b0);
    for (int j = 0; j < 20; j++) step(1'b0, 1'b0);
    check_int("both_mode_count", pc2 - b2, 2);
    check_int("rise_mode_count", pc0 - b0, 1);
    check_int("fall_mode_count", pc1 - b1, 1);

    // One-cycle reset while WAIT_HIGH holds cnt=2, din kept high.
    brc = rc0;
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (r0 && first < 0) first = i;
    end
    check_int("rst_rise_latency", first, 5);
    check_int("rst_rise_count", rc0 - brc, 1);

    // Falling side: 3-cycle dip is rejected, final fall accepted 5 edges later.
    bfc = fc0;
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    for (int j = 0; j < 6; j++) step(1'b1, 1'b0);
    check_int("dip_no_fall", fc0 - bfc, 0);
    check_int("dip_level", int'(l0), 1);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (f0 && first < 0) first = i;
    end
    check_int("fall_latency", first, 5);

    // Reset on the very edge a rise would have been produced.
    brc = rc0;
    for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
    check_int("rst_beats_pulse", rc0 - brc, 0);

    // Randomized bounce bursts settling to a stable level.
    b0 = pc0; b1 = pc1;
    exp_falls = 0;
    exp_rises = 0;
    consec    = 0;
    prev      = 1'b0;
    for (int b = 0; b < 50; b++) begin
      v     = !prev;
      nruns = $urandom_range(1, 5);
      for (int r = 0; r < nruns; r++) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) step(v, 1'b0);
        v = !v;
      end
      target = 1'($urandom_range(0, 1));
      for (int j = 0; j < 10; j++) step(target, 1'b0);
      if (prev && !target) exp_falls++;
      if (!prev && target) exp_rises++;
      prev = target;
    end
    check_int("random_fall_count", pc1 - b1, exp_falls);
    check_int("random_rise_count", pc0 - b0, exp_rises);
    check_int("no_back_to_back", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
